// File: rtl/calc_operand_sequencer.sv
// Steps a calculator front panel through operand A, operand B and mode entry, then issues the operation.
// Optional macro CALC_SEQ_ECHO_EN enables the {mode, op_b, op_a} display echo with live entry preview.
module calc_operand_sequencer #(
    parameter int unsigned MODE_MAX = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_next,
    input  logic        key_back,
    input  logic [3:0]  sw_data,
    input  logic        issue_ready,
    output logic [3:0]  op_a,
    output logic [3:0]  op_b,
    output logic [3:0]  mode,
    output logic        issue_valid,
    output logic [1:0]  stage,
    output logic        err,
    output logic [7:0]  issue_count,
    output logic [11:0] echo
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned EW = 12;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_MODE  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_op_a;
    logic [DW-1:0]   r_op_b;
    logic [DW-1:0]   r_mode;
    logic            r_err;
    logic [CW-1:0]   r_count;
    logic            r_prev_next;
    logic            r_prev_back;

    state_t          w_state_nxt;
    logic [DW-1:0]   w_op_a_nxt;
    logic [DW-1:0]   w_op_b_nxt;
    logic [DW-1:0]   w_mode_nxt;
    logic            w_err_nxt;
    logic [CW-1:0]   w_count_nxt;

    logic            w_next_press;
    logic            w_back_press;
    logic            w_both_press;
    logic            w_handshake;
    logic            w_mode_legal;

    assign w_next_press = key_next & ~r_prev_next;
    assign w_back_press = key_back & ~r_prev_back;
    assign w_both_press = w_next_press & w_back_press;
    assign w_handshake  = (r_state == S_ISSUE) & issue_ready;
    assign w_mode_legal = (32'(sw_data) <= MODE_MAX);

    // State and captured-field registers; previous key levels reset high so held keys need a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_A;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_mode      <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_prev_next <= 1'b1;
            r_prev_back <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_op_a      <= w_op_a_nxt;
            r_op_b      <= w_op_b_nxt;
            r_mode      <= w_mode_nxt;
            r_err       <= w_err_nxt;
            r_count     <= w_count_nxt;
            r_prev_next <= key_next;
            r_prev_back <= key_back;
        end
    end

    // Next-state logic; a completed handshake outranks any key press in S_ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        w_op_a_nxt  = r_op_a;
        w_op_b_nxt  = r_op_b;
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        w_err_nxt   = w_both_press;

        if (w_handshake) begin
            w_state_nxt = S_A;
            w_count_nxt = r_count + CW'(1);
        end else if (!w_both_press) begin
            case (r_state)
                S_A: begin
                    if (w_next_press) begin
                        w_op_a_nxt  = sw_data;
                        w_state_nxt = S_B;
                    end else if (w_back_press) begin
                        w_op_a_nxt  = '0;
                    end
                end
                S_B: begin
                    if (w_next_press) begin
                        w_op_b_nxt  = sw_data;
                        w_state_nxt = S_MODE;
                    end else if (w_back_press) begin
                        w_state_nxt = S_A;
                    end
                end
                S_MODE: begin
                    if (w_next_press) begin
                        if (w_mode_legal) begin
                            w_mode_nxt  = sw_data;
                            w_state_nxt = S_ISSUE;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end else if (w_back_press) begin
                        w_state_nxt = S_B;
                    end
                end
                S_ISSUE: begin
                    if (w_back_press) begin
                        w_state_nxt = S_MODE;
                    end
                end
                default: w_state_nxt = S_A;
            endcase
        end
    end

    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign mode        = r_mode;
    assign err         = r_err;
    assign issue_count = r_count;
    assign stage       = r_state;
    assign issue_valid = (r_state == S_ISSUE);

`ifdef CALC_SEQ_ECHO_EN
    // Field currently being entered previews the live switch value.
    always_comb begin
        echo = {r_mode, r_op_b, r_op_a};
        case (r_state)
            S_A:     echo = {r_mode, r_op_b, sw_data};
            S_B:     echo = {r_mode, sw_data, r_op_a};
            default: echo = {r_mode, r_op_b, r_op_a};
        endcase
    end
`else
    assign echo = EW'(0);
`endif

endmodule

// File: doc/calc_operand_sequencer.md
CALC_OPERAND_SEQUENCER -- requirements
Module: calc_operand_sequencer

Interface
REQ-001 Parameter MODE_MAX, default 11, highest legal calculator mode code.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_next  input  1  debounced button level, active-high; confirms current entry.
REQ-005 key_back  input  1  debounced button level, active-high; steps back or clears.
REQ-006 sw_data  input  4  switch nibble sampled as operand or mode code.
REQ-007 issue_ready  input  1  downstream calculator accepts the issued operation.
REQ-008 op_a  output  4  captured first operand.
REQ-009 op_b  output  4  captured second operand.
REQ-010 mode  output  4  captured operation mode, 0..MODE_MAX.
REQ-011 issue_valid  output  1  op_a/op_b/mode form a complete operation.
REQ-012 stage  output  2  current state: 0 S_A, 1 S_B, 2 S_MODE, 3 S_ISSUE.
REQ-013 err  output  1  one-cycle pulse on a rejected input.
REQ-014 issue_count  output  8  number of completed handshakes.
REQ-015 echo  output  12  {mode, op_b, op_a} for display drivers.

Function
REQ-016 Press = key level 1 this cycle with registered previous level 0; state acts on the same rising edge that samples the press, outputs valid one cycle later.
REQ-017 S_A: next press loads op_a <= sw_data, goes S_B; back press clears op_a to 0, stays S_A.
REQ-018 S_B: next press loads op_b <= sw_data, goes S_MODE; back press returns S_A, op_a retained.
REQ-019 S_MODE: next press with sw_data <= MODE_MAX loads mode, goes S_ISSUE; sw_data > MODE_MAX leaves mode unchanged, stays S_MODE, pulses err; back press returns S_B.
REQ-020 S_ISSUE: issue_valid = 1 combinationally from stage; op_a, op_b, mode held stable while valid.
REQ-021 Handshake completes on any edge with issue_valid and issue_ready both 1: go S_A, issue_count increments, operands retained.
REQ-022 issue_count wraps 255 -> 0.
REQ-023 S_ISSUE back press without issue_ready withdraws valid, returns S_MODE; back press with issue_ready in same cycle: handshake wins, back ignored.
REQ-024 next press in S_ISSUE ignored.
REQ-025 next and back presses on the same edge in any state: both ignored, err pulses, state unchanged.
REQ-026 Held key produces exactly one press regardless of hold length.

Reset
REQ-027 rst dominates all inputs: stage S_A, op_a/op_b/mode 0, issue_valid 0, err 0, issue_count 0.
REQ-028 Previous-key registers reset to 1, so keys held through reset produce no press until released and pressed again.
REQ-029 rst during S_ISSUE drops issue_valid next cycle with no count increment.

Configuration
REQ-030 CALC_SEQ_ECHO_EN defined: echo = {mode, op_b, op_a}, but while in S_A/S_B the field being entered shows live sw_data.
REQ-031 CALC_SEQ_ECHO_EN undefined: echo tied to 12'h000; all other behaviour identical.

Verification
REQ-032 Reset, sw_data=5 next, sw_data=3 next, sw_data=2 next -> op_a=5, op_b=3, mode=2, stage=3, issue_valid=1; issue_ready=1 one cycle -> stage=0, issue_count=1.
REQ-033 In S_MODE sw_data=12 (MODE_MAX=11) next -> err high exactly one cycle, stage stays 2, mode unchanged.
REQ-034 key_next held 100 cycles in S_A -> single transition to S_B only.
REQ-035 S_ISSUE, back and issue_ready same edge -> stage=0, count increments; back alone -> stage=2, issue_valid=0.
REQ-036 255 handshakes then one more -> issue_count 0; rst asserted mid-S_ISSUE with keys held -> all outputs 0, no press after rst release until key released.
